// File: rtl/tab_pkg.sv
// rtl/tab_pkg.sv - shared state encoding, BCD digit width and digit clamp for bcd_tab_accum
package tab_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } tab_state_e;

  // Step digits outside 0..9 are treated as 9 so the adder only ever sees valid BCD.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single-digit BCD adder with carry in/out
//   a, b : BCD digit operands (0..9)
//   cin  : carry in from the lower digit
//   sum  : BCD result digit
//   cout : carry out to the next digit
module bcd_digit_add
  import tab_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};

  always_comb begin
    cout = (raw > 5'd9);
    // raw - 10 and raw + 6 agree modulo 16, which avoids a borrow bit.
    sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
  end

endmodule

// File: rtl/bcd_tab_accum.sv
// rtl/bcd_tab_accum.sv - gated multi-digit BCD accumulator with prescaler and wrap/saturate overflow
//   clk, reset(active-low async), clear(sync)
//   start, allow_start, stop, over : run gating levels
//   step_bcd : packed BCD amount added per completed prescale period
//   sum_bcd  : packed BCD accumulated value
//   state    : 0=IDLE 1=RUN 2=HOLD 3=DONE
//   running, add_pulse, overflow : registered status flags
module bcd_tab_accum
  import tab_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1,
  parameter int SAT_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    allow_start,
  input  logic                    stop,
  input  logic                    over,
  input  logic [BCD_W*DIGITS-1:0] step_bcd,
  output logic [BCD_W*DIGITS-1:0] sum_bcd,
  output logic [1:0]              state,
  output logic                    running,
  output logic                    add_pulse,
  output logic                    overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(PRESCALE - 1);
  localparam logic [BCD_W*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  tab_state_e              state_q, state_d;
  logic [BCD_W*DIGITS-1:0] sum_q, sum_d;
  logic [PW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    pulse_q, pulse_d;
  logic                    run_q;

  logic [BCD_W*DIGITS-1:0] step_c;
  logic [BCD_W*DIGITS-1:0] add_sum;
  logic [DIGITS:0]         carry;
  logic                    tick;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign step_c[i*BCD_W +: BCD_W] = clamp_digit(step_bcd[i*BCD_W +: BCD_W]);

    bcd_digit_add u_add (
      .a    (sum_q[i*BCD_W +: BCD_W]),
      .b    (step_c[i*BCD_W +: BCD_W]),
      .cin  (carry[i]),
      .sum  (add_sum[i*BCD_W +: BCD_W]),
      .cout (carry[i+1])
    );
  end

  assign tick = start && allow_start && !stop && !over && (state_q != ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      run_q   <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_DONE) begin
      // frozen until clear or reset
    end else if (over) begin
      state_d = ST_DONE;
    end else if (stop) begin
      // prescale progress survives the pause
      state_d = ST_HOLD;
    end else if (tick) begin
      state_d = ST_RUN;
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        pulse_d = 1'b1;
        sum_d   = add_sum;
        if (carry[DIGITS]) begin
          ovf_d = 1'b1;
          if (SAT_MODE != 0) begin
            sum_d   = ALL_NINES;
            state_d = ST_DONE;
          end
        end
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  always_comb begin
    sum_bcd   = sum_q;
    state     = state_q;
    running   = run_q;
    add_pulse = pulse_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_bcd_tab_accum.sv
// tb/tb_bcd_tab_accum.sv - scoreboard bench for bcd_tab_accum, two parameter sets driven in lockstep
module tb_bcd_tab_accum;

  typedef struct packed {
    logic [11:0] sum;
    logic [1:0]  st;
    logic        run;
    logic        pulse;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0, start = 1'b0, allow_start = 1'b0, stop = 1'b0, over = 1'b0;
  logic [11:0] step0 = '0;
  logic [7:0]  step1 = '0;
  logic [11:0] sum0;
  logic [7:0]  sum1;
  logic [1:0]  st0, st1;
  logic        run0, run1, pulse0, pulse1, ovf0, ovf1;

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  // reference model: plain integers, per instance
  int   dig [2] = '{3, 2};
  int   pre [2] = '{1, 4};
  int   sat [2] = '{0, 1};
  int   ms  [2];
  int   mc  [2];
  int   mst [2];
  logic mo  [2];

  always #5 clk = ~clk;

  bcd_tab_accum #(.DIGITS(3), .PRESCALE(1), .SAT_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .allow_start(allow_start),
    .stop(stop), .over(over), .step_bcd(step0), .sum_bcd(sum0), .state(st0),
    .running(run0), .add_pulse(pulse0), .overflow(ovf0)
  );

  bcd_tab_accum #(.DIGITS(2), .PRESCALE(4), .SAT_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .allow_start(allow_start),
    .stop(stop), .over(over), .step_bcd(step1), .sum_bcd(sum1), .state(st1),
    .running(run1), .add_pulse(pulse1), .overflow(ovf1)
  );

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model_out(input int k, input logic p);
    exp_t e;
    e.sum   = to_bcd(ms[k]);
    e.st    = 2'(mst[k]);
    e.run   = (mst[k] == 1);
    e.pulse = p;
    e.ovf   = mo[k];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mc[k] = 0; mst[k] = 0; mo[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic c, s, a, p, o,
                            input logic [11:0] stp, output exp_t e);
    int   lim, sv, w;
    logic pl;
    int   nib;
    pl = 1'b0;
    lim = 1;
    sv = 0;
    w = 1;
    for (int i = 0; i < dig[k]; i++) begin
      nib = int'(stp[4*i +: 4]);
      if (nib > 9) nib = 9;
      sv += nib * w;
      w *= 10;
      lim *= 10;
    end
    if (c) begin
      ms[k] = 0; mc[k] = 0; mst[k] = 0; mo[k] = 1'b0;
    end else if (mst[k] == 3) begin
    end else if (o) begin
      mst[k] = 3;
    end else if (p) begin
      mst[k] = 2;
    end else if (s && a) begin
      mst[k] = 1;
      mc[k]++;
      if (mc[k] == pre[k]) begin
        mc[k] = 0;
        pl = 1'b1;
        ms[k] += sv;
        if (ms[k] >= lim) begin
          mo[k] = 1'b1;
          if (sat[k] != 0) begin
            ms[k] = lim - 1;
            mst[k] = 3;
          end else begin
            ms[k] -= lim;
          end
        end
      end
    end
    e = model_out(k, pl);
  endtask

  task automatic cycle(input logic c, s, a, p, o, input logic [11:0] s0, input logic [7:0] s1);
    exp_t e;
    @(negedge clk);
    reset = 1'b1; clear = c; start = s; allow_start = a; stop = p; over = o;
    step0 = s0; step1 = s1;
    model_step(0, c, s, a, p, o, s0, e);
    q0.push_back(e);
    model_step(1, c, s, a, p, o, {4'h0, s1}, e);
    q1.push_back(e);
    mon_en = 1'b1;
  endtask

  // reset asserted mid-cycle; outputs must clear before the next edge
  task automatic mid_reset();
    @(negedge clk);
    clear = 1'b0; start = 1'b0; allow_start = 1'b0; stop = 1'b0; over = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_sum0", sum0, 12'h000);
    check("async_rst_st0", {10'b0, st0}, 12'h000);
    check("async_rst_ovf0", {11'b0, ovf0}, 12'h000);
    check("async_rst_sum1", {4'h0, sum1}, 12'h000);
    check("async_rst_st1", {10'b0, st1}, 12'h000);
    model_reset();
    if (mon_en) begin
      q0.push_back(model_out(0, 1'b0));
      q1.push_back(model_out(1, 1'b0));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
          e = q0.pop_front();
          check("d0_sum", sum0, e.sum);
          check("d0_state", {10'b0, st0}, {10'b0, e.st});
          check("d0_running", {11'b0, run0}, {11'b0, e.run});
          check("d0_add_pulse", {11'b0, pulse0}, {11'b0, e.pulse});
          check("d0_overflow", {11'b0, ovf0}, {11'b0, e.ovf});
          e = q1.pop_front();
          check("d1_sum", {4'h0, sum1}, e.sum);
          check("d1_state", {10'b0, st1}, {10'b0, e.st});
          check("d1_running", {11'b0, run1}, {11'b0, e.run});
          check("d1_add_pulse", {11'b0, pulse1}, {11'b0, e.pulse});
          check("d1_overflow", {11'b0, ovf1}, {11'b0, e.ovf});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic c, s, a, p, o;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_sum0", sum0, 12'h000);
    check("init_state0", {10'b0, st0}, 12'h000);
    check("init_pulse0", {11'b0, pulse0}, 12'h000);
    check("init_ovf1", {11'b0, ovf1}, 12'h000);

    // count 001..012 with unit steps
    repeat (12) cycle(0, 1, 1, 0, 0, 12'h001, 8'h01);
    // bring dut0 to 042, then reset asynchronously
    cycle(0, 1, 1, 0, 0, 12'h030, 8'h00);
    mid_reset();
    // prescaler held across a pause
    repeat (2) cycle(0, 1, 1, 0, 0, 12'h005, 8'h05);
    repeat (5) cycle(0, 1, 1, 1, 0, 12'h005, 8'h05);
    repeat (2) cycle(0, 1, 1, 0, 0, 12'h005, 8'h05);
    // 995 + 7 wrap on dut0; repeated 99s saturate dut1
    cycle(1, 0, 0, 0, 0, 12'h000, 8'h00);
    cycle(0, 1, 1, 0, 0, 12'h995, 8'h99);
    repeat (3) cycle(0, 1, 1, 0, 0, 12'h000, 8'h99);
    repeat (2) cycle(0, 1, 1, 0, 0, 12'h007, 8'h07);
    repeat (4) cycle(0, 1, 1, 0, 0, 12'h000, 8'h99);
    // over with a tick, then clear+over+stop, then start without permission
    cycle(1, 0, 0, 0, 0, 12'h000, 8'h00);
    cycle(0, 1, 1, 0, 0, 12'h010, 8'h10);
    cycle(0, 1, 1, 0, 1, 12'h010, 8'h10);
    cycle(0, 1, 1, 0, 0, 12'h010, 8'h10);
    cycle(1, 0, 0, 1, 1, 12'h010, 8'h10);
    repeat (3) cycle(0, 1, 0, 0, 0, 12'h010, 8'h10);
    // clamp of out-of-range step digits
    cycle(0, 1, 1, 0, 0, 12'hFAB, 8'hCD);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        c = ($urandom_range(0, 99) < 4);
        o = ($urandom_range(0, 99) < 3);
        p = ($urandom_range(0, 99) < 8);
        s = ($urandom_range(0, 99) < 90);
        a = ($urandom_range(0, 99) < 90);
        cycle(c, s, a, p, o, 12'($urandom), 8'($urandom));
      end
    end

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_tab_accum.md
Name: bcd_tab_accum

Overview:
Parametrised multi-digit BCD accumulator for the tablet datapath, succeeding the fixed 3-digit, +1 tab counter. It keeps the start/allow_start/stop/over gating and adds configurable digit count, a tick prescaler, a BCD step value per add, and wrap or saturate overflow handling. It runs as a small run/hold/done state machine. Outputs feed the digit display path directly as packed BCD.

Parameters:
DIGITS, 3, number of BCD digits in the sum (>=1); digit 0 is least significant.
PRESCALE, 1, qualified ticks per add (>=1); 1 means add on every qualified tick.
SAT_MODE, 0, 0 = wrap modulo 10^DIGITS on overflow; 1 = clamp to all-9s and enter DONE.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
clear  in  1  synchronous clear of sum, prescaler, overflow and state.
start  in  1  run request (level).
allow_start  in  1  run permission (level).
stop  in  1  pause request (level).
over  in  1  terminate request (level); freezes the block until clear or reset.
step_bcd  in  4*DIGITS  packed BCD amount added per completed prescale period.
sum_bcd  out  4*DIGITS  packed BCD accumulated value.
state  out  2  0=IDLE, 1=RUN, 2=HOLD, 3=DONE.
running  out  1  high when state==RUN.
add_pulse  out  1  one-cycle pulse, coincident with each sum update.
overflow  out  1  sticky; set when a carry leaves the top digit.

Behaviour:
- Reset (reset==0, asynchronous): sum_bcd=0, state=IDLE, prescale count=0, add_pulse=0, overflow=0.
- All outputs are registered.
- Priority, highest first: reset > clear > over > stop > tick.
- Qualified tick: start && allow_start && !stop && !over, with state in {IDLE, RUN, HOLD}.
- clear: next state IDLE; sum=0; prescale count=0; overflow=0; add_pulse=0. Any tick in the same cycle is ignored.
- over (without clear): next state DONE. A tick in the same cycle is discarded. In DONE, sum, prescale count and overflow are frozen; only clear or reset exit DONE.
- stop (without over or clear) in IDLE, RUN or HOLD: next state HOLD. The prescale count is retained, not zeroed.
- Qualified tick: next state RUN, so the IDLE->RUN or HOLD->RUN transition cycle itself counts.
  - Prescale count increments.
  - When the count equals PRESCALE-1, it resets to 0 and an add occurs.
- Cycle with no qualified tick and no stop/over/clear: state and all counters hold. RUN stays RUN; there is no implicit HOLD.
- Add: sum_bcd <= sum_bcd + step_bcd as DIGITS-digit decimal addition with ripple carry (digit sum >9 subtracts 10 and carries 1).
  - The result is visible after the sampling edge (1-cycle latency).
  - add_pulse is high in that same cycle only.
- step_bcd digits above 9 are clamped to 9 before addition.
- Carry out of the top digit:
  - SAT_MODE=0: keep the wrapped low digits, set overflow, stay RUN.
  - SAT_MODE=1: sum_bcd = all 9s, set overflow, next state DONE.
- overflow stays set until clear or reset.
- Prescale counter width is max(1, clog2(PRESCALE)). With PRESCALE=1 every qualified tick adds.

Decomposition:
- Package tab_pkg: state encoding constants (IDLE/RUN/HOLD/DONE), BCD_W=4, and the digit clamp function.
- Sub-module bcd_digit_add: one-digit BCD adder (a, b, cin -> sum, cout), instantiated DIGITS times in a ripple chain inside a generate loop.

Test Plan:
1. DIGITS=3, PRESCALE=1, step=001, 12 qualified ticks from IDLE -> sum 001..012, with the 010 carry on the 10th tick; add_pulse high 12 cycles; state RUN.
2. sum=042, drive reset low asynchronously mid-cycle -> sum 000, state IDLE, overflow 0 immediately, before the next edge.
3. PRESCALE=4, step=005: 2 ticks, stop high 5 cycles (state HOLD, sum 000), then 2 ticks -> exactly one add, sum 005, one add_pulse.
4. SAT_MODE=0, sum=995, step=007, one tick -> sum 002, overflow 1, state RUN; next tick -> 009, overflow still 1.
5. SAT_MODE=1, sum=995, step=007 -> sum 999, overflow 1, state DONE; further ticks leave 999; clear -> 000, IDLE, overflow 0.
6. sum=010, tick with over=1 same cycle -> sum 010, state DONE; clear+over+stop same cycle -> IDLE, sum 000; allow_start=0 with start=1 -> no change.
